// File: rtl/kf8237_channel_address_counter_bank_if.sv
// kf8237_channel_address_counter_bank_if: register-bus and transfer-control signals of the channel address/count bank.
interface kf8237_channel_address_counter_bank_if #(
    parameter int CHANNELS  = 4,
    parameter int REG_WIDTH = 16
);
    logic                 clock_n_en;
    logic [7:0]           internal_data_bus;
    logic [7:0]           read_data;
    logic [CHANNELS-1:0]  write_base_and_current_address;
    logic [CHANNELS-1:0]  write_base_and_current_word_count;
    logic [CHANNELS-1:0]  read_current_address;
    logic [CHANNELS-1:0]  read_current_word_count;
    logic                 clear_byte_pointer;
    logic                 master_clear;
    logic [CHANNELS-1:0]  transfer_register_select;
    logic                 initialize_current_register;
    logic                 next_word;
    logic                 address_hold_config;
    logic                 decrement_address_config;
    logic [CHANNELS-1:0]  autoinitialize_config;
    logic                 read_terminal_count_status;
    logic                 terminal_count;
    logic [CHANNELS-1:0]  terminal_count_status;
    logic                 update_high_address;
    logic [REG_WIDTH-1:0] transfer_address;

    modport master (
        output clock_n_en, internal_data_bus, write_base_and_current_address,
               write_base_and_current_word_count, read_current_address, read_current_word_count,
               clear_byte_pointer, master_clear, transfer_register_select, initialize_current_register,
               next_word, address_hold_config, decrement_address_config, autoinitialize_config,
               read_terminal_count_status,
        input  read_data, terminal_count, terminal_count_status, update_high_address, transfer_address
    );

    modport slave (
        input  clock_n_en, internal_data_bus, write_base_and_current_address,
               write_base_and_current_word_count, read_current_address, read_current_word_count,
               clear_byte_pointer, master_clear, transfer_register_select, initialize_current_register,
               next_word, address_hold_config, decrement_address_config, autoinitialize_config,
               read_terminal_count_status,
        output read_data, terminal_count, terminal_count_status, update_high_address, transfer_address
    );
endinterface

// File: rtl/kf8237_channel_address_counter_bank.sv
// kf8237_channel_address_counter_bank: per-channel base/current address and word-count registers with
// byte-serial access, advance, autoinitialise reload and terminal-count status.
module kf8237_channel_address_counter_bank #(
    parameter int CHANNELS  = 4,
    parameter int REG_WIDTH = 16
) (
    input logic clock,
    input logic reset,
    kf8237_channel_address_counter_bank_if.slave bus
);
    localparam int NBYTES = REG_WIDTH / 8;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [REG_WIDTH-1:0] base_address       [CHANNELS];
    logic [REG_WIDTH-1:0] current_address    [CHANNELS];
    logic [REG_WIDTH-1:0] base_word_count    [CHANNELS];
    logic [REG_WIDTH-1:0] current_word_count [CHANNELS];
    logic [IW-1:0]        byte_index;
    logic                 read_prev;
    logic                 tc_pulse;
    logic [CHANNELS-1:0]  status;
    logic [REG_WIDTH-1:0] xfer_address;
    logic [CW-1:0]        active;
    logic                 active_valid;
    logic [REG_WIDTH-1:0] next_address;
    logic [7:0]           read_byte;
    logic                 read_any;
    logic                 write_any;
    logic                 advance;
    logic                 terminal;

    assign read_any  = |{bus.read_current_address, bus.read_current_word_count};
    assign write_any = |{bus.write_base_and_current_address, bus.write_base_and_current_word_count};

    // Reverse scans so the lowest set bit is the last assignment and wins.
    always_comb begin
        active = '0;
        active_valid = 1'b0;
        read_byte = 8'h00;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (bus.transfer_register_select[i]) begin
                active = CW'(i);
                active_valid = 1'b1;
            end
            if (bus.read_current_word_count[i])
                read_byte = current_word_count[i][{byte_index, 3'b000} +: 8];
        end
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (bus.read_current_address[i])
                read_byte = current_address[i][{byte_index, 3'b000} +: 8];
    end

    assign next_address = bus.address_hold_config ? current_address[active] :
                          bus.decrement_address_config ? current_address[active] - REG_WIDTH'(1) :
                          current_address[active] + REG_WIDTH'(1);
    // A write strobe or initialise on the active channel outranks the advance.
    assign advance = bus.next_word & bus.clock_n_en & active_valid & ~bus.initialize_current_register &
                     ~(bus.write_base_and_current_address[active] | bus.write_base_and_current_word_count[active]);
    assign terminal = advance && (current_word_count[active] == '0);

    assign bus.read_data             = read_byte;
    assign bus.terminal_count        = tc_pulse;
    assign bus.terminal_count_status = status;
    assign bus.transfer_address      = xfer_address;
    assign bus.update_high_address   = active_valid && !bus.address_hold_config &&
                                       (next_address[REG_WIDTH-1:8] != xfer_address[REG_WIDTH-1:8]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_index <= '0;
            read_prev <= 1'b0;
            tc_pulse <= 1'b0;
            status <= '0;
            xfer_address <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                base_address[c] <= '0;
                current_address[c] <= '0;
                base_word_count[c] <= '0;
                current_word_count[c] <= '0;
            end
        end else if (bus.master_clear) begin
            byte_index <= '0;
            read_prev <= 1'b0;
            tc_pulse <= 1'b0;
            status <= '0;
            xfer_address <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                base_address[c] <= '0;
                current_address[c] <= '0;
                base_word_count[c] <= '0;
                current_word_count[c] <= '0;
            end
        end else begin
            byte_index <= bus.clear_byte_pointer ? '0 :
                          !(write_any || (read_prev && !read_any)) ? byte_index :
                          (byte_index == IW'(NBYTES - 1)) ? '0 : byte_index + IW'(1);
            read_prev <= read_any;
            tc_pulse <= terminal;
            status <= (bus.read_terminal_count_status ? '0 : status) |
                      (terminal ? CHANNELS'(1) << active : '0);
            if (bus.clock_n_en && active_valid)
                xfer_address <= current_address[active];
            for (int c = 0; c < CHANNELS; c++) begin
                if (bus.write_base_and_current_address[c] || bus.write_base_and_current_word_count[c]) begin
                    if (bus.write_base_and_current_address[c]) begin
                        base_address[c][{byte_index, 3'b000} +: 8] <= bus.internal_data_bus;
                        current_address[c][{byte_index, 3'b000} +: 8] <= bus.internal_data_bus;
                    end
                    if (bus.write_base_and_current_word_count[c]) begin
                        base_word_count[c][{byte_index, 3'b000} +: 8] <= bus.internal_data_bus;
                        current_word_count[c][{byte_index, 3'b000} +: 8] <= bus.internal_data_bus;
                    end
                end else if (active_valid && active == CW'(c)) begin
                    if (bus.initialize_current_register || (terminal && bus.autoinitialize_config[c])) begin
                        current_address[c] <= base_address[c];
                        current_word_count[c] <= base_word_count[c];
                    end else if (advance) begin
                        current_address[c] <= next_address;
                        current_word_count[c] <= current_word_count[c] - REG_WIDTH'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_kf8237_channel_address_counter_bank.sv
// tb_kf8237_channel_address_counter_bank: directed checks of a 16-bit and a 24-bit bank driven in parallel.
module tb_kf8237_channel_address_counter_bank;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       cne, mc, cbp, init, nw, hold, dec, rtcs;
    logic [7:0] din;
    logic [3:0] wa, wc, ra, rc, sel, autoi;
    logic [31:0] v16, v24;
    int checks = 0;
    int failures = 0;

    kf8237_channel_address_counter_bank_if #(.CHANNELS(4), .REG_WIDTH(16)) b16();
    kf8237_channel_address_counter_bank_if #(.CHANNELS(4), .REG_WIDTH(24)) b24();

    assign {b16.clock_n_en, b16.internal_data_bus, b16.write_base_and_current_address,
            b16.write_base_and_current_word_count, b16.read_current_address, b16.read_current_word_count,
            b16.clear_byte_pointer, b16.master_clear, b16.transfer_register_select,
            b16.initialize_current_register, b16.next_word, b16.address_hold_config,
            b16.decrement_address_config, b16.autoinitialize_config, b16.read_terminal_count_status} =
           {cne, din, wa, wc, ra, rc, cbp, mc, sel, init, nw, hold, dec, autoi, rtcs};
    assign {b24.clock_n_en, b24.internal_data_bus, b24.write_base_and_current_address,
            b24.write_base_and_current_word_count, b24.read_current_address, b24.read_current_word_count,
            b24.clear_byte_pointer, b24.master_clear, b24.transfer_register_select,
            b24.initialize_current_register, b24.next_word, b24.address_hold_config,
            b24.decrement_address_config, b24.autoinitialize_config, b24.read_terminal_count_status} =
           {cne, din, wa, wc, ra, rc, cbp, mc, sel, init, nw, hold, dec, autoi, rtcs};

    kf8237_channel_address_counter_bank #(.CHANNELS(4), .REG_WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .bus(b16.slave));
    kf8237_channel_address_counter_bank #(.CHANNELS(4), .REG_WIDTH(24)) dut24 (
        .clock(clock), .reset(reset), .bus(b24.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic clr_ptr;
        cbp = 1'b1;
        step;
        cbp = 1'b0;
    endtask

    task automatic wr(input bit cnt, input int ch, input int n, input logic [31:0] v);
        clr_ptr;
        for (int i = 0; i < n; i++) begin
            din = v[8*i +: 8];
            if (cnt) wc[ch] = 1'b1; else wa[ch] = 1'b1;
            step;
            wa = '0;
            wc = '0;
        end
    endtask

    task automatic rd(input bit cnt, input int ch, input int n, input bit clr,
                      output logic [31:0] o16, output logic [31:0] o24);
        if (clr) clr_ptr;
        o16 = '0;
        o24 = '0;
        for (int i = 0; i < n; i++) begin
            if (cnt) rc[ch] = 1'b1; else ra[ch] = 1'b1;
            #1;
            o16[8*i +: 8] = b16.read_data;
            o24[8*i +: 8] = b24.read_data;
            step;
            ra = '0;
            rc = '0;
            step;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        {cne, mc, cbp, init, nw, hold, dec, rtcs} = '0;
        din = '0;
        {wa, wc, ra, rc, sel, autoi} = '0;
        repeat (2) step;
        reset = 1'b0;
        check("rst_tc", b16.terminal_count, 0);
        check("rst_status", b16.terminal_count_status, 0);
        check("rst_xfer", b16.transfer_address, 0);
        check("rst_rdata", b16.read_data, 0);
        check("rst_uha", b16.update_high_address, 0);

        // 24-bit byte-serial write/read and index wrap
        clr_ptr;
        for (int i = 0; i < 3; i++) begin
            din = (i == 0) ? 8'h56 : (i == 1) ? 8'h34 : 8'h12;
            wa[2] = 1'b1;
            step;
            wa = '0;
        end
        rd(0, 2, 3, 0, v16, v24);
        check("w24_read", v24, 32'h123456);
        rd(0, 2, 1, 0, v16, v24);
        check("w24_wrap", v24, 32'h56);

        // ch1 increment across the 0x00FF/0x0100 boundary to terminal count
        wr(1, 1, 2, 2);
        wr(0, 1, 2, 16'h00FF);
        sel = 4'b0010;
        cne = 1'b1;
        step;
        check("inc_xfer0", b16.transfer_address, 16'h00FF);
        check("inc_uha0", b16.update_high_address, 1);
        nw = 1'b1; step; nw = 1'b0;
        check("inc_tc1", b16.terminal_count, 0);
        step;
        check("inc_xfer1", b16.transfer_address, 16'h0100);
        check("inc_uha1", b16.update_high_address, 0);
        nw = 1'b1; step; nw = 1'b0;
        check("inc_tc2", b16.terminal_count, 0);
        step;
        check("inc_xfer2", b16.transfer_address, 16'h0101);
        nw = 1'b1; step; nw = 1'b0;
        check("inc_tc3", b16.terminal_count, 1);
        check("inc_status", b16.terminal_count_status, 4'b0010);
        step;
        check("inc_tc_pulse", b16.terminal_count, 0);
        cne = 1'b0;
        rd(0, 1, 2, 1, v16, v24);
        check("inc_addr", v16, 16'h0102);
        rd(1, 1, 2, 1, v16, v24);
        check("inc_cnt_wrap", v16, 16'hFFFF);

        // ch0 autoinitialise
        sel = 4'b0001;
        autoi = 4'b0001;
        wr(0, 0, 2, 16'h1000);
        wr(1, 0, 2, 0);
        cne = 1'b1; nw = 1'b1; step; nw = 1'b0; cne = 1'b0;
        check("ai_tc", b16.terminal_count, 1);
        check("ai_status", b16.terminal_count_status, 4'b0011);
        rd(0, 0, 2, 1, v16, v24);
        check("ai_addr", v16, 16'h1000);
        rd(1, 0, 2, 1, v16, v24);
        check("ai_cnt", v16, 0);
        cne = 1'b1; nw = 1'b1; step; nw = 1'b0; cne = 1'b0;
        check("ai_tc_again", b16.terminal_count, 1);

        // status set and clear in the same cycle
        autoi = '0;
        sel = 4'b1000;
        wr(1, 3, 2, 0);
        rtcs = 1'b1; cne = 1'b1; nw = 1'b1;
        step;
        nw = 1'b0;
        check("st_set_wins", b16.terminal_count_status, 4'b1000);
        step;
        rtcs = 1'b0; cne = 1'b0;
        check("st_cleared", b16.terminal_count_status, 0);

        // asynchronous reset mid-advance
        sel = 4'b0100;
        wr(1, 2, 2, 5);
        cne = 1'b1; nw = 1'b1;
        step;
        #2 reset = 1'b1;
        #1;
        check("ar_tc", b16.terminal_count, 0);
        check("ar_status", b16.terminal_count_status, 0);
        check("ar_xfer", b16.transfer_address, 0);
        check("ar_rdata", b16.read_data, 0);
        check("ar_uha", b16.update_high_address, 0);
        @(negedge clock);
        reset = 1'b0;
        step;
        nw = 1'b0; cne = 1'b0;
        check("ar_tc_after", b16.terminal_count, 1);

        // decrement wrap and address hold
        wr(0, 2, 2, 0);
        wr(1, 2, 2, 3);
        dec = 1'b1;
        cne = 1'b1; nw = 1'b1; step; nw = 1'b0; cne = 1'b0;
        rd(0, 2, 2, 1, v16, v24);
        check("dec_wrap", v16, 16'hFFFF);
        hold = 1'b1;
        #1;
        check("hold_uha", b16.update_high_address, 0);
        cne = 1'b1; nw = 1'b1; step; nw = 1'b0; cne = 1'b0;
        rd(0, 2, 2, 1, v16, v24);
        check("hold_addr", v16, 16'hFFFF);
        rd(1, 2, 2, 1, v16, v24);
        check("hold_cnt", v16, 1);
        hold = 1'b0; dec = 1'b0;

        // no channel selected, then master clear
        sel = '0;
        #1;
        check("nosel_uha", b16.update_high_address, 0);
        cne = 1'b1; nw = 1'b1; step; nw = 1'b0; cne = 1'b0;
        check("nosel_tc", b16.terminal_count, 0);
        mc = 1'b1; step; mc = 1'b0;
        check("mc_status", b16.terminal_count_status, 0);
        check("mc_xfer", b16.transfer_address, 0);
        rd(1, 2, 2, 1, v16, v24);
        check("mc_cnt", v16, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kf8237_channel_address_counter_bank.md
Name: kf8237_channel_address_counter_bank

Overview:
- Parametrised bank of per-channel base/current address and word-count registers for the KF8237 family DMA datapath.
- Generalised in channel count and register width; loaded and read byte-serially over the 8-bit internal bus.
- Adds per-channel autoinitialise reload on terminal count, a terminal-count pulse, and sticky terminal-count status bits.
- Sits between the command/register decode logic and the transfer timing FSM.

Parameters:
CHANNELS, 4, number of DMA channels (1..8)
REG_WIDTH, 16, address and count width in bits (16, 24 or 32); NBYTES = REG_WIDTH/8

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
clock_n_en  in  1  transfer-phase enable; gates address/count advance and transfer_address capture
internal_data_bus  in  8  write data
read_data  out  8  selected register byte
write_base_and_current_address  in  CHANNELS  one-hot byte write strobe; loads base and current address
write_base_and_current_word_count  in  CHANNELS  one-hot byte write strobe; loads base and current count
read_current_address  in  CHANNELS  read strobe, address
read_current_word_count  in  CHANNELS  read strobe, count
clear_byte_pointer  in  1  byte index <= 0
master_clear  in  1  synchronous clear of all state
transfer_register_select  in  CHANNELS  active channel; lowest set bit wins
initialize_current_register  in  1  current <= base for active channel
next_word  in  1  advance active channel (qualified by clock_n_en)
address_hold_config  in  1  address not modified on advance
decrement_address_config  in  1  address -1 (else +1)
autoinitialize_config  in  CHANNELS  per-channel reload on terminal count
read_terminal_count_status  in  1  clears all status bits
terminal_count  out  1  one-cycle pulse on terminal advance
terminal_count_status  out  CHANNELS  sticky per-channel TC flags
update_high_address  out  1  next address differs from transfer_address in bits [REG_WIDTH-1:8]
transfer_address  out  REG_WIDTH  registered address of active channel

Behaviour:
- One clock (clock); reset asynchronous, active-high. Reset and master_clear: all registers, byte index, status, transfer_address = 0; terminal_count = 0.
- Byte index: 0..NBYTES-1.
  - Advances, wrapping to 0, on any cycle with a nonzero write strobe.
  - Also advances on the cycle after both read-strobe vectors fall from nonzero to zero.
  - clear_byte_pointer takes priority over advance.
- Writes: byte[index] of the base and current register of every strobed channel <= internal_data_bus, in the same edge.
- read_data is combinational: byte[index] of the lowest-indexed asserted read strobe; address strobes beat count strobes; 0 if none.
- Per-channel update priority: master_clear > write > initialize_current_register > (next_word & clock_n_en).
- Advance of active channel ch:
  - count != 0: count <= count-1; address <= address per hold/decrement config, modulo 2^REG_WIDTH.
  - count == 0 (terminal):
    - terminal_count pulses high the next cycle; status[ch] set.
    - autoinitialize_config[ch] = 1: current address/count <= base.
    - Otherwise: address advances as above and count wraps to all ones.
- Status: read_terminal_count_status clears all bits at the edge. A set for the same channel in the same cycle wins.
- transfer_address <= current address of active channel when clock_n_en; holds when clock_n_en = 0 or no channel is selected.
- update_high_address is combinational. It compares the would-be advanced address of the active channel against transfer_address; 0 when hold is set or no channel is selected.
- No select bit set: next_word and initialize_current_register are ignored.

Test Plan:
- CHANNELS=4, REG_WIDTH=24: write 0x56,0x34,0x12 to ch2 address; read back via read_current_address[2] pulses -> 0x56, 0x34, 0x12; byte index wraps to 0.
- ch1 count=2, address=0x00FF, increment, 3 advances -> addresses 0x0100, 0x0101, 0x0102; update_high_address = 1 before the first advance only; terminal_count pulses on the 3rd advance; count = 0xFFFF; status[1] = 1.
- ch0 autoinit, base address 0x1000, count 0: one advance -> current reverts to 0x1000/0; status[0] set; next advance pulses terminal_count again.
- Status set and read_terminal_count_status in the same cycle for ch3 -> status[3] stays 1; next read clears it to 0.
- Assert reset mid-advance with ch2 count=5 -> all outputs 0 immediately; after release, next_word on ch2 gives terminal_count (count was 0).
- Decrement with address 0x0000 -> 0xFFFF (REG_WIDTH=16); address_hold_config -> unchanged while count still decrements.
